// File: rtl/mem_ctrl_multiport.sv
// rtl/mem_ctrl_multiport.sv - byte-maskable 1W/R-read register file with clear sequencer and write-first bypass
module mem_ctrl_multiport #(
  parameter int N = 32,
  parameter int M = 5,
  parameter int R = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  output logic             busy,
  input  logic             wr_en,
  input  logic [M-1:0]     wr_addr,
  input  logic [N-1:0]     wr_data,
  input  logic [N/8-1:0]   wr_be,
  input  logic [R-1:0]     rd_en,
  input  logic [R*M-1:0]   rd_addr,
  output logic [R*N-1:0]   rd_data,
  output logic [R-1:0]     rd_valid
);

  localparam int B     = N / 8;
  localparam int DEPTH = 1 << M;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t         state, next_state;
  logic [M-1:0]   clr_cnt;
  logic [N-1:0]   mem [DEPTH];
  logic [N-1:0]   rd_word [R];
  logic           wr_act;

  assign wr_act = (state == IDLE) && wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      busy    <= 1'b1;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == CLEAR);
      // Held at zero outside CLEAR so every sequence starts at address 0.
      if (state == CLEAR) clr_cnt <= clr_cnt + M'(1);
      else                clr_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_cnt == {M{1'b1}}) next_state = IDLE;
      IDLE:    if (clear) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // No reset on the array so it can map onto RAM; only the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      if (reset_n) mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < B; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write-first: enabled bytes of a same-address write override the stored word.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      rd_word[i] = mem[rd_addr[i*M +: M]];
      for (int b = 0; b < B; b++) begin
        if (wr_act && wr_be[b] && (wr_addr == rd_addr[i*M +: M]))
          rd_word[i][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < R; i++) begin
        rd_valid[i] <= (state == IDLE) && rd_en[i];
        if ((state == IDLE) && rd_en[i]) rd_data[i*N +: N] <= rd_word[i];
      end
    end
  end

endmodule
